// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: two result FIFOs (ALU, LSB) drained round-robin onto one registered CDB.
// Optional CDB_ARB_STATS_EN adds a saturating stall_cnt of contested cycles.
module cdb_arbiter #(
  parameter int unsigned LAB_W = 4,
  parameter int unsigned VAL_W = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             flush,
  input  logic             alu_valid,
  input  logic [LAB_W-1:0] alu_lab,
  input  logic [VAL_W-1:0] alu_val,
  output logic             alu_ready,
  input  logic             lsb_valid,
  input  logic [LAB_W-1:0] lsb_lab,
  input  logic [VAL_W-1:0] lsb_val,
  output logic             lsb_ready,
  output logic             cdb_en,
  output logic [LAB_W-1:0] cdb_lab,
  output logic [VAL_W-1:0] cdb_val,
  output logic             cdb_src
`ifdef CDB_ARB_STATS_EN
  ,
  output logic [31:0]      stall_cnt
`endif
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned NSRC  = 2;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_LSB = 1'b1
  } src_e;

  logic [LAB_W-1:0] lab_mem  [NSRC][DEPTH];
  logic [VAL_W-1:0] val_mem  [NSRC][DEPTH];
  logic [PTR_W-1:0] wr_ptr_q [NSRC];
  logic [PTR_W-1:0] wr_ptr_d [NSRC];
  logic [PTR_W-1:0] rd_ptr_q [NSRC];
  logic [PTR_W-1:0] rd_ptr_d [NSRC];
  logic [CNT_W-1:0] cnt_q    [NSRC];
  logic [CNT_W-1:0] cnt_d    [NSRC];

  logic             in_valid  [NSRC];
  logic [LAB_W-1:0] in_lab    [NSRC];
  logic [VAL_W-1:0] in_val    [NSRC];
  logic             ready     [NSRC];
  logic             push      [NSRC];
  logic             pop       [NSRC];
  logic             not_empty [NSRC];

  src_e             last_q, last_d, gnt_src;
  logic             gnt_en, active;
  logic             cdb_en_d, cdb_src_d;
  logic [LAB_W-1:0] cdb_lab_d;
  logic [VAL_W-1:0] cdb_val_d;

  assign in_valid[0] = alu_valid;
  assign in_lab[0]   = alu_lab;
  assign in_val[0]   = alu_val;
  assign in_valid[1] = lsb_valid;
  assign in_lab[1]   = lsb_lab;
  assign in_val[1]   = lsb_val;

  assign active    = rdy_in && !flush;
  assign alu_ready = ready[0];
  assign lsb_ready = ready[1];

  // Ready depends on occupancy only, so a same-cycle pop never frees a full FIFO.
  always_comb begin : fifo_ctrl
    for (int s = 0; s < 2; s++) begin
      not_empty[s] = (cnt_q[s] != '0);
      ready[s]     = (cnt_q[s] < CNT_W'(DEPTH));
      push[s]      = active && in_valid[s] && ready[s] && (in_lab[s] != '0);
    end
  end

  // Round-robin between non-empty FIFOs; a lone non-empty FIFO wins outright.
  always_comb begin : grant
    gnt_en  = active && (not_empty[0] || not_empty[1]);
    gnt_src = SRC_ALU;
    if (not_empty[0] && not_empty[1]) begin
      gnt_src = (last_q == SRC_LSB) ? SRC_ALU : SRC_LSB;
    end else if (!not_empty[0]) begin
      gnt_src = SRC_LSB;
    end
    pop[0] = gnt_en && (gnt_src == SRC_ALU);
    pop[1] = gnt_en && (gnt_src == SRC_LSB);
  end

  always_comb begin : next_state
    last_d    = last_q;
    cdb_en_d  = cdb_en;
    cdb_lab_d = cdb_lab;
    cdb_val_d = cdb_val;
    cdb_src_d = cdb_src;
    for (int s = 0; s < 2; s++) begin
      cnt_d[s]    = cnt_q[s];
      wr_ptr_d[s] = wr_ptr_q[s];
      rd_ptr_d[s] = rd_ptr_q[s];
    end
    if (rdy_in) begin
      cdb_en_d = gnt_en;
      if (flush) begin
        for (int s = 0; s < 2; s++) begin
          cnt_d[s]    = '0;
          wr_ptr_d[s] = '0;
          rd_ptr_d[s] = '0;
        end
      end else begin
        for (int s = 0; s < 2; s++) begin
          if (push[s]) wr_ptr_d[s] = wr_ptr_q[s] + PTR_W'(1);
          if (pop[s])  rd_ptr_d[s] = rd_ptr_q[s] + PTR_W'(1);
          cnt_d[s] = cnt_q[s] + CNT_W'(push[s]) - CNT_W'(pop[s]);
        end
        if (gnt_en) begin
          last_d    = gnt_src;
          cdb_lab_d = lab_mem[gnt_src][rd_ptr_q[gnt_src]];
          cdb_val_d = val_mem[gnt_src][rd_ptr_q[gnt_src]];
          cdb_src_d = (gnt_src == SRC_LSB);
        end
      end
    end
  end

  always_ff @(posedge clk) begin : state_reg
    if (rst_in) begin
      for (int s = 0; s < 2; s++) begin
        cnt_q[s]    <= '0;
        wr_ptr_q[s] <= '0;
        rd_ptr_q[s] <= '0;
      end
      last_q  <= SRC_LSB;
      cdb_en  <= 1'b0;
      cdb_lab <= '0;
      cdb_val <= '0;
      cdb_src <= 1'b0;
    end else begin
      for (int s = 0; s < 2; s++) begin
        cnt_q[s]    <= cnt_d[s];
        wr_ptr_q[s] <= wr_ptr_d[s];
        rd_ptr_q[s] <= rd_ptr_d[s];
      end
      last_q  <= last_d;
      cdb_en  <= cdb_en_d;
      cdb_lab <= cdb_lab_d;
      cdb_val <= cdb_val_d;
      cdb_src <= cdb_src_d;
    end
  end

  // Payload storage needs no reset; occupancy is tracked by the counters.
  always_ff @(posedge clk) begin : fifo_mem
    for (int s = 0; s < 2; s++) begin
      if (push[s]) begin
        lab_mem[s][wr_ptr_q[s]] <= in_lab[s];
        val_mem[s][wr_ptr_q[s]] <= in_val[s];
      end
    end
  end

`ifdef CDB_ARB_STATS_EN
  logic [31:0] stall_d;

  always_comb begin : stall_next
    stall_d = stall_cnt;
    if (active && not_empty[0] && not_empty[1] && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_d = stall_cnt + 32'd1;
    end
  end

  always_ff @(posedge clk) begin : stall_reg
    if (rst_in) stall_cnt <= '0;
    else        stall_cnt <= stall_d;
  end
`endif

endmodule
